ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
//  Sequencer for the RV32M multiply/divide unit beside the EX-stage ALU.
//  Accepts one M-extension op from the ID/EX buffer and runs iterative shift-add (MUL*)
//  or restoring shift-subtract (DIV*/REM*) over XLEN cycles.
//  Holds the pipeline with a stall while busy, then returns the result in place of alu_out.
// PARAMETERS
//  XLEN   32                 operand/result width
//  CNT_W  $clog2(XLEN)+1     iteration counter width
// PORTS
//  clk        in   1     system clock
//  rst        in   1     asynchronous, active-high reset
//  start      in   1     EX holds a valid M-op (level; held stable while stall=1)
//  mdop       in   3     funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  a          in   XLEN  rs1 value
//  b          in   XLEN  rs2 value
//  flush      in   1     kill in-flight op (branch/jalr redirect)
//  stall      out  1     freeze IF/ID/EX; combinational
//  done       out  1     result valid this cycle (1-cycle pulse)
//  result     out  XLEN  final result; valid only when done=1
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; stall=0, done=0, result=0; all internal registers 0.
//  Outputs:
//   - stall = start & (state!=DONE) & ~flush
//   - done  = (state==DONE)
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   - IDLE, start & ~flush: latch |a|,|b|, result signs, op; cnt=XLEN; go CALC.
//     DIV/REM with b==0, or signed a=0x80000000 & b=-1: go DONE directly (no CALC).
//   - CALC: one iteration per cycle, cnt--; when cnt hits 0, go DONE.
//   - DONE: apply sign correction, drive result with done=1, stall=0.
//     Pipeline advances on this edge; next state IDLE.
//  Latency:
//   - normal op: start sampled at edge 0, done in cycle XLEN+1 (33).
//   - special case: done in cycle 1.
//   - stall is high every cycle before done.
//  Back-to-back: start still high in the IDLE cycle after DONE is a new instruction.
//   Accept it and reassert stall that same cycle; no idle bubble is required.
//  Arithmetic:
//   - Multiply: 2*XLEN product register.
//     MUL  -> low word.
//     MULH/MULHSU/MULHU -> high word.
//     Negate the 64-bit product when the signs of the signed operands differ.
//   - Divide: XLEN-bit quotient and remainder.
//     Quotient sign = sa^sb.
//     Remainder sign = sign of dividend.
//   - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a.
//   - Overflow (0x80000000 / -1): DIV -> 0x80000000; REM -> 0.
//  Boundaries:
//   - flush in any state: next state IDLE, no done, stall=0 that cycle.
//     flush beats start in IDLE.
//   - rst mid-op: async return to IDLE, operands discarded.
//   - start dropping while in CALC (must not happen): treat as flush.
//   - cnt never wraps below 0.
// STRUCTURE
//  rv32i_types: mdop_t enum of the funct3 codes, muldiv_state_t {IDLE,CALC,DONE}.
//  One always_ff block with async reset for state, counter and operand/accumulator
//  registers, plus always_comb blocks for next state and outputs.
//  No sub-module; the iteration step is inline.
//  EX stage muxes result into alu_out when done=1.
// TESTING
//  1. MUL a=7, b=-3 -> result 0xFFFFFFEB; done at cycle 33; stall=1 for cycles 0..32.
//  2. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//     MULH a=0x80000000, b=2 -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD.
//     REM -7/2 -> 0xFFFFFFFF.
//     DIVU 100/7 -> 14.
//     REMU 100/7 -> 2.
//  4. DIV 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, both done at cycle 1.
//     DIV 0x80000000/-1 -> 0x80000000.
//     REM 0x80000000/-1 -> 0.
//  5. flush at cycle 10 of a DIV -> no done pulse, stall=0, IDLE next cycle.
//     rst asserted at cycle 5 -> outputs return to reset values immediately.
//  6. Back-to-back MUL 3*4 then DIVU 9/2, start held high:
//     results 12 and 4; second stall rises in the cycle right after the first done.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_ctrl_pkg
//  Purpose  : Shared types for the RV32M multiply/divide sequencer.
//             - mdop_t         : funct3 encodings of the M-extension ops
//             - muldiv_state_t : sequencer states
//             - helpers that classify an op (divide? operand signedness?)
//  Revision : 1.0  initial release
// ============================================================================
package ex_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input mdop_t op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input mdop_t op);
        logic r;
        case (op)
            MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is treated as signed by MUL, MULH, DIV and REM.
    function automatic logic op_b_signed(input mdop_t op);
        logic r;
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: r = 1'b1;
            default:                         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : ex_muldiv_ctrl_pkg
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv_ctrl
//  Purpose  : Iterative RV32M multiply/divide sequencer beside the EX ALU.
//             Multiplies by shift-add and divides by restoring shift-subtract
//             on operand magnitudes, one bit per cycle over XLEN cycles, then
//             applies sign correction in the DONE cycle. Holds the pipeline
//             with a combinational stall while the op is in flight.
//  Ports    : clk     in   system clock
//             rst     in   asynchronous active-high reset
//             start   in   EX holds a valid M-op (level, stable while stalled)
//             mdop    in   funct3 of the M-op
//             a, b    in   rs1 / rs2 values
//             flush   in   kill the in-flight op (redirect)
//             stall   out  freeze IF/ID/EX (combinational)
//             done    out  one-cycle result-valid pulse
//             result  out  final result, meaningful only while done=1
//  Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mdop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // Registers. r_hi/r_lo form the 2*XLEN product for multiplies and
    // hold {remainder, quotient-shifting-in} for divides; r_opb holds the
    // multiplicand or divisor magnitude.
    // ------------------------------------------------------------------
    muldiv_state_t   r_state;
    muldiv_state_t   w_state_nxt;
    mdop_t           r_op;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opb;
    logic [CNT_W-1:0] r_cnt;
    logic            r_neg;       // product / quotient must be negated
    logic            r_rem_neg;   // remainder must be negated (dividend sign)
    logic            r_spec;      // divide-by-zero or signed overflow
    logic [XLEN-1:0] r_spec_val;

    // ------------------------------------------------------------------
    // Operand decode in the accept cycle
    // ------------------------------------------------------------------
    mdop_t           w_op;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;
    logic            w_accept;

    always_comb begin
        w_op    = mdop_t'(mdop);
        w_sa    = op_a_signed(w_op) & a[XLEN-1];
        w_sb    = op_b_signed(w_op) & b[XLEN-1];
        w_abs_a = w_sa ? (~a + 1'b1) : a;
        w_abs_b = w_sb ? (~b + 1'b1) : b;
        w_div0  = op_is_div(w_op) && (b == '0);
        w_ovf   = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                  (a == c_int_min) && (b == {XLEN{1'b1}});
        w_special = w_div0 | w_ovf;
        // funct3[1] selects remainder ops within the divide family.
        if (w_op[1]) begin
            w_special_val = w_div0 ? a : '0;
        end else begin
            w_special_val = w_div0 ? {XLEN{1'b1}} : c_int_min;
        end
        w_accept = (r_state == IDLE) & start & ~flush;
    end

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi;
    logic [XLEN-1:0] w_mul_lo;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ok;
    logic [XLEN-1:0] w_div_hi;
    logic [XLEN-1:0] w_div_lo;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set, then shift the whole product right keeping the carry.
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
        w_mul_hi  = w_mul_sum[XLEN:1];
        w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only when it did not borrow.
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opb};
        w_div_ok    = ~w_div_diff[XLEN];
        w_div_hi    = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
        w_div_lo    = {r_lo[XLEN-2:0], w_div_ok};
    end

    // ------------------------------------------------------------------
    // State, counter and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= MD_MUL;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op       <= w_op;
                r_hi       <= '0;
                r_lo       <= w_abs_a;
                r_opb      <= w_abs_b;
                r_cnt      <= CNT_W'(XLEN);
                r_neg      <= w_sa ^ w_sb;
                r_rem_neg  <= w_sa;
                r_spec     <= w_special;
                r_spec_val <= w_special_val;
            end else if (r_state == CALC) begin
                if (op_is_div(r_op)) begin
                    r_hi <= w_div_hi;
                    r_lo <= w_div_lo;
                end else begin
                    r_hi <= w_mul_hi;
                    r_lo <= w_mul_lo;
                end
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !flush) begin
                    w_state_nxt = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                // A dropped start means the op was abandoned upstream.
                if (flush || !start) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    always_comb begin
        w_prod_fix = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
        w_quo_fix  = r_neg ? (~r_lo + 1'b1) : r_lo;
        w_rem_fix  = r_rem_neg ? (~r_hi + 1'b1) : r_hi;

        // rst gating keeps stall at its reset value while reset is held.
        stall  = start & (r_state != DONE) & ~flush & ~rst;
        done   = (r_state == DONE);
        result = '0;
        if (r_state == DONE) begin
            if (r_spec) begin
                result = r_spec_val;
            end else begin
                case (r_op)
                    MD_MUL:                       result = w_prod_fix[XLEN-1:0];
                    MD_MULH, MD_MULHSU, MD_MULHU: result = w_prod_fix[2*XLEN-1:XLEN];
                    MD_DIV, MD_DIVU:              result = w_quo_fix;
                    default:                      result = w_rem_fix;
                endcase
            end
        end
    end

endmodule : ex_muldiv_ctrl
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv_ctrl
//  Purpose  : Scoreboard bench for ex_muldiv_ctrl. Stimulus pushes expected
//             result and latency computed with plain 64-bit arithmetic; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mdop   (mdop),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference: architectural RV32M results from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        longint          p;
        longint unsigned up;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = '0;
        case (op)
            3'd0: begin p = sx * sy;            r = p[31:0];  end
            3'd1: begin p = sx * sy;            r = p[63:32]; end
            3'd2: begin p = sx * longint'(uy);  r = p[63:32]; end
            3'd3: begin up = ux * uy;           r = up[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin p = sx / sy; r = p[31:0]; end
            end
            3'd5: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin up = ux / uy; r = up[31:0]; end
            end
            3'd6: begin
                if (y == 0) r = x;
                else begin p = sx % sy; r = p[31:0]; end
            end
            default: begin
                if (y == 0) r = x;
                else begin up = ux % uy; r = up[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] x,
                                   input logic [31:0] y);
        bit spec;
        spec = op[2] && ((y == 0) ||
               (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        return spec ? 1 : 33;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h, required no done",
                         result);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("result op=%0d a=%08h b=%08h", mon_e.op, mon_e.x, mon_e.y),
                    result, mon_e.exp);
                chk($sformatf("latency op=%0d a=%08h b=%08h", mon_e.op, mon_e.x, mon_e.y),
                    32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
        end
    end

    // Issue one op, check stall every busy cycle, optionally keep start high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit hold);
        bit got;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b1;
        mdop  = op;
        a     = x;
        b     = y;
        sbq.push_back('{op, x, y, ref_md(op, x, y), ref_lat(op, x, y), cyc});
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            chk("stall_busy", 32'(stall), 32'd1);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout op=%0d: got no done in 40 cycles, required done", op);
            void'(sbq.pop_front());
        end else begin
            chk("stall_at_done", 32'(stall), 32'd0);
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        mdop  = 3'd0;
        a     = '0;
        b     = '0;
        #2;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed arithmetic and special cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);           // MUL 7*-3
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);   // MULHU
        run_op(3'd1, 32'h8000_0000, 32'd2, 1'b0);           // MULH
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);   // MULHSU -1*(2^32-1)
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);           // DIV -7/2
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);           // REM -7/2
        run_op(3'd5, 32'd100, 32'd7, 1'b0);                 // DIVU
        run_op(3'd7, 32'd100, 32'd7, 1'b0);                 // REMU
        run_op(3'd4, 32'd100, 32'd0, 1'b0);                 // DIV by 0
        run_op(3'd6, 32'd100, 32'd0, 1'b0);                 // REM by 0
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   // DIV overflow
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);   // REM overflow

        // Flush at cycle 10 of a DIV; the op restarted right after must
        // take the full latency, proving the sequencer went back to IDLE.
        @(posedge clk);
        #1;
        start = 1'b1;
        mdop  = 3'd4;
        a     = 32'd1000;
        b     = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        run_op(3'd5, 32'd1000, 32'd3, 1'b0);

        // Asynchronous reset at cycle 5 of a MUL
        @(posedge clk);
        #1;
        start = 1'b1;
        mdop  = 3'd0;
        a     = 32'd5;
        b     = 32'd6;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd5, 32'd6, 1'b0);

        // Back-to-back with start held high
        run_op(3'd0, 32'd3, 32'd4, 1'b1);
        run_op(3'd5, 32'd9, 32'd2, 1'b0);

        // Randomised ops, random back-to-back
        for (int i = 0; i < 50; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   bit'($urandom_range(0, 1)));
        end

        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ex_muldiv_ctrl
`default_nettype wire
